// File: rtl/cobra_hex_display_pkg.sv
// Shared constants for the CYBERcobra hex display: digit count and
// active-low {g,f,e,d,c,b,a} segment patterns for 0..F.
package cobra_disp_pkg;

  localparam int DIGITS = 8;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/cobra_hex_display_hex_to_seg7.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_seg7
  import cobra_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/cobra_hex_display.sv
// Eight-digit multiplexed hex display of the CYBERcobra out_o word. The value
// is sampled once per scan frame so a frame never mixes two values.
module cobra_hex_display
  import cobra_disp_pkg::*;
#(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  input  logic        hold_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        change_o
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0]              div_cnt;
  logic [2:0]                 idx;
  logic [31:0]                shadow;
  logic [DIGITS-1:0][3:0]     nib_arr;
  logic [DIGITS-1:0]          digit_blank;
  logic [3:0]                 nibble;
  logic [6:0]                 seg_dec;
  logic                       wrap;
  logic                       capture;

  assign wrap    = (div_cnt == CW'(REFRESH_DIV - 1));
  // Capture only at the very end of the frame, after digit 7 has been shown.
  assign capture = wrap && (idx == 3'd7) && !hold_i;

  assign nib_arr = shadow;
  assign nibble  = nib_arr[idx];

  // A digit goes dark when it and every digit above it are zero.
  assign digit_blank[0] = 1'b0;
  for (genvar k = 1; k < DIGITS; k++) begin : g_blank
    assign digit_blank[k] = BLANK_LEADING && (shadow[31:4*k] == '0);
  end

  hex_to_seg7 u_dec (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt  <= '0;
      idx      <= '0;
      shadow   <= '0;
      an_o     <= 8'hFF;
      seg_o    <= SEG_BLANK;
      dp_o     <= 1'b1;
      change_o <= 1'b0;
    end else begin
      if (wrap) begin
        div_cnt <= '0;
        idx     <= idx + 3'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      change_o <= capture && (data_i != shadow);
      if (capture) shadow <= data_i;
      an_o  <= digit_blank[idx] ? 8'hFF : ~(8'b1 << idx);
      seg_o <= seg_dec;
      dp_o  <= !((idx == 3'd0) && hold_i);
    end
  end

endmodule

// File: tb/tb_cobra_hex_display.sv
// Bench for cobra_hex_display: a cycle model feeds a scoreboard that checks
// both a plain and a leading-blank instance, plus directed scenario checks.
module tb_cobra_hex_display;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic [31:0] data;
  logic [7:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1, chg0, chg1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] hex_tbl [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  always #5 clk = ~clk;

  cobra_hex_display #(.REFRESH_DIV(R), .BLANK_LEADING(1'b0)) u_plain (
    .clk_i(clk), .rst_i(rst), .data_i(data), .hold_i(hold),
    .an_o(an0), .seg_o(seg0), .dp_o(dp0), .change_o(chg0)
  );

  cobra_hex_display #(.REFRESH_DIV(R), .BLANK_LEADING(1'b1)) u_blank (
    .clk_i(clk), .rst_i(rst), .data_i(data), .hold_i(hold),
    .an_o(an1), .seg_o(seg1), .dp_o(dp1), .change_o(chg1)
  );

  typedef struct packed {
    logic [7:0] an0;
    logic [7:0] an1;
    logic [6:0] seg;
    logic       dp;
    logic       chg;
  } exp_t;

  exp_t sb[$];
  int          m_cnt = 0;
  int          m_idx = 0;
  logic [31:0] m_sh  = '0;

  // Model: expected registered outputs are pushed at each edge.
  always @(posedge clk) begin
    exp_t e;
    logic [3:0] nib;
    if (rst) begin
      e = '{an0: 8'hFF, an1: 8'hFF, seg: 7'h7F, dp: 1'b1, chg: 1'b0};
      m_cnt = 0; m_idx = 0; m_sh = '0;
    end else begin
      nib   = 4'((m_sh >> (4 * m_idx)) & 32'hF);
      e.an0 = ~(8'd1 << m_idx);
      e.an1 = (m_idx != 0 && (m_sh >> (4 * m_idx)) == 0) ? 8'hFF : e.an0;
      e.seg = hex_tbl[nib];
      e.dp  = !(m_idx == 0 && hold);
      e.chg = 1'b0;
      if (m_cnt == R - 1) begin
        if (m_idx == 7 && !hold) begin
          e.chg = (data != m_sh);
          m_sh  = data;
        end
        m_cnt = 0;
        m_idx = (m_idx + 1) % 8;
      end else begin
        m_cnt++;
      end
    end
    sb.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_chk++;
      if ({an0, an1, seg0, seg1, dp0, dp1, chg0, chg1} !==
          {e.an0, e.an1, e.seg, e.seg, e.dp, e.dp, e.chg, e.chg}) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t got an=%h/%h seg=%h/%h dp=%b/%b chg=%b/%b exp an=%h/%h seg=%h dp=%b chg=%b",
                 $time, an0, an1, seg0, seg1, dp0, dp1, chg0, chg1,
                 e.an0, e.an1, e.seg, e.dp, e.chg);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] d);
    rst = 1'b1; hold = 1'b0; data = d;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_chk++;
      if ({an0, seg0, dp0, chg0} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_vals got an=%h seg=%h dp=%b chg=%b exp FF 7F 1 0", an0, seg0, dp0, chg0);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      cyc();
      n_chk++;
      if (seg0 !== 7'h40 || chg0 !== (k == 32)) begin
        n_fail++;
        $display("FAIL first_frame k=%0d got seg=%h chg=%b exp 40 %b", k, seg0, chg0, k == 32);
      end
    end
  endtask

  task automatic test_capture();
    int pulses = 0;
    logic [7:0] ea;
    logic [6:0] es;
    int d;
    do_reset(32'h00000F0C);
    for (int k = 1; k <= 64; k++) begin
      cyc();
      if (chg0) begin
        pulses++;
        n_chk++;
        if (k != 32) begin
          n_fail++;
          $display("FAIL capture_pulse_time got k=%0d exp 32", k);
        end
      end
      if (k >= 33) begin
        d  = (k - 33) / 4;
        ea = ~(8'd1 << d);
        es = (d == 0) ? 7'h46 : (d == 2) ? 7'h0E : 7'h40;
        n_chk++;
        if (an0 !== ea || seg0 !== es) begin
          n_fail++;
          $display("FAIL capture_scan k=%0d got an=%h seg=%h exp %h %h", k, an0, seg0, ea, es);
        end
      end
    end
    n_chk++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL capture_pulse_count got %0d exp 1", pulses);
    end
  endtask

  task automatic test_blank();
    int dark = 0;
    int d;
    do_reset(32'h00000F0C);
    for (int k = 1; k <= 64; k++) begin
      cyc();
      if (k >= 33) begin
        d = (k - 33) / 4;
        if (an1 == 8'hFF) dark++;
        n_chk++;
        if (an1[7:3] !== 5'h1F || (d < 3 && an1 !== ~(8'd1 << d))) begin
          n_fail++;
          $display("FAIL blank_scan k=%0d got an=%h digit=%0d", k, an1, d);
        end
      end
    end
    n_chk++;
    if (dark != 20) begin
      n_fail++;
      $display("FAIL blank_dark_cycles got %0d exp 20", dark);
    end
  endtask

  task automatic test_hold();
    int pulses = 0;
    do_reset(32'h12345678);
    for (int k = 1; k <= 32; k++) cyc();
    n_chk++;
    if (chg0 !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_first_capture got chg=%b exp 1", chg0);
    end
    hold = 1'b1; data = 32'h8;
    for (int k = 1; k <= 96; k++) begin
      cyc();
      n_chk++;
      if (chg0 !== 1'b0 || dp0 !== (an0 != 8'hFE) ||
          (an0 == 8'h7F && seg0 !== 7'h79)) begin
        n_fail++;
        $display("FAIL hold_frozen k=%0d got an=%h seg=%h dp=%b chg=%b", k, an0, seg0, dp0, chg0);
      end
    end
    hold = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      cyc();
      if (chg0) pulses++;
    end
    n_chk++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL hold_release_pulse got %0d exp 1", pulses);
    end
    for (int k = 1; k <= 4; k++) begin
      cyc();
      n_chk++;
      if (an0 !== 8'hFE || seg0 !== 7'h00) begin
        n_fail++;
        $display("FAIL hold_new_value got an=%h seg=%h exp FE 00", an0, seg0);
      end
    end
  endtask

  task automatic test_unchanged();
    int pulses = 0;
    do_reset(32'h5A5A5A5A);
    for (int k = 1; k <= 96; k++) begin
      cyc();
      if (chg0) pulses++;
    end
    n_chk++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL unchanged_pulses got %0d exp 1", pulses);
    end
  endtask

  task automatic test_mid_reset();
    do_reset(32'hCAFEBABE);
    for (int k = 1; k <= 53; k++) cyc();
    n_chk++;
    if (an0 !== 8'hDF) begin
      n_fail++;
      $display("FAIL midreset_pre got an=%h exp DF", an0);
    end
    rst = 1'b1;
    cyc();
    n_chk++;
    if ({an0, seg0, dp0, chg0} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_vals got an=%h seg=%h dp=%b chg=%b exp FF 7F 1 0", an0, seg0, dp0, chg0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      n_chk++;
      if (an0 !== ((k <= 4) ? 8'hFE : 8'hFD) || seg0 !== 7'h40) begin
        n_fail++;
        $display("FAIL midreset_restart k=%0d got an=%h seg=%h", k, an0, seg0);
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    hold = 1'b0;
    data = 32'hFFFFFFFF;
    test_reset();
    test_capture();
    test_blank();
    test_hold();
    test_unchanged();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
